// File: rtl/ifu_fetch_pkg.sv
// Shared fetch-stage definitions: core widths, fetch FSM states and the
// buffered {pc, inst} entry layout.
package ifu_fetch_pkg;

    localparam int CPU_WIDTH  = 64;
    localparam int INST_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        DRAIN = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [CPU_WIDTH-1:0]  pc;
        logic [INST_WIDTH-1:0] inst;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small power-of-two FIFO with synchronous clear; exposes the head entry and
// the occupancy count so the owner can reserve slots ahead of a push.
module fetch_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 96
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clr,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       din,
    output logic [$clog2(DEPTH):0] count,
    output logic [WIDTH-1:0]       head
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    // Pointers are exactly log2(DEPTH) bits wide, so increments wrap naturally.
    always_comb begin
        do_pop   = pop & ~clr & (count_q != '0);
        do_push  = push & ~clr & ((count_q != CW'(DEPTH)) | do_pop);
        wr_ptr_d = wr_ptr_q + AW'(do_push);
        rd_ptr_d = rd_ptr_q + AW'(do_pop);
        count_d  = count_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        if (clr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    assign count = count_q;
    assign head  = mem_q[rd_ptr_q];

endmodule

// File: rtl/ifu_fetch.sv
// Instruction-fetch front end: one-outstanding memory requests, wrong-path
// squashing on flush, and a small {pc, inst} buffer toward IF/ID.
module ifu_fetch #(
    parameter int CPU_WIDTH  = ifu_fetch_pkg::CPU_WIDTH,
    parameter int INST_WIDTH = ifu_fetch_pkg::INST_WIDTH,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic [CPU_WIDTH-1:0]  i_pc,
    input  logic                  i_flush,
    output logic                  o_pcwen,
    output logic                  o_req_valid,
    input  logic                  i_req_ready,
    output logic [CPU_WIDTH-1:0]  o_req_addr,
    input  logic                  i_rsp_valid,
    input  logic [INST_WIDTH-1:0] i_rsp_data,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic [INST_WIDTH-1:0] o_inst,
    output logic [CPU_WIDTH-1:0]  o_pc
);

    import ifu_fetch_pkg::*;

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int EW = CPU_WIDTH + INST_WIDTH;

    fetch_state_e         state_q, state_d;
    logic [CPU_WIDTH-1:0] req_pc_q, req_pc_d;
    logic [CW-1:0]        count;
    logic [EW-1:0]        head;
    logic                 space, fire, push, pop;

    // Outputs are gated by reset so nothing is requested or presented while
    // the core is held in reset, even though the idle state alone would allow it.
    always_comb begin
        space       = count < CW'(FIFO_DEPTH);
        o_req_valid = i_rst_n & (state_q == IDLE) & space & ~i_flush;
        o_req_addr  = i_pc;
        fire        = o_req_valid & i_req_ready;
        o_pcwen     = fire | (i_flush & i_rst_n);
        o_valid     = i_rst_n & (count != '0) & ~i_flush;
        pop         = o_valid & i_ready;
        push        = (state_q == WAIT) & i_rsp_valid & ~i_flush;
    end

    always_comb begin
        state_d  = state_q;
        req_pc_d = req_pc_q;
        case (state_q)
            IDLE: begin
                if (fire) begin
                    state_d  = WAIT;
                    req_pc_d = i_pc;
                end
            end
            WAIT: begin
                if (i_rsp_valid) begin
                    state_d = IDLE;
                end else if (i_flush) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (i_rsp_valid) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= IDLE;
            req_pc_q <= '0;
        end else begin
            state_q  <= state_d;
            req_pc_q <= req_pc_d;
        end
    end

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (EW)
    ) u_fifo (
        .clk   (i_clk),
        .rst_n (i_rst_n),
        .clr   (i_flush),
        .push  (push),
        .pop   (pop),
        .din   ({req_pc_q, i_rsp_data}),
        .count (count),
        .head  (head)
    );

    assign o_inst = head[INST_WIDTH-1:0];
    assign o_pc   = head[EW-1:INST_WIDTH];

endmodule

// File: tb/tb_ifu_fetch.sv
// Randomized self-checking bench for ifu_fetch against a transaction-level
// model of the fetch queue, the outstanding request and the PC unit.
module tb_ifu_fetch;

    import ifu_fetch_pkg::*;

    localparam int DEPTH = 2;

    logic                  i_clk = 1'b0;
    logic                  i_rst_n = 1'b0;
    logic [CPU_WIDTH-1:0]  i_pc = '0;
    logic                  i_flush = 1'b0;
    logic                  o_pcwen;
    logic                  o_req_valid;
    logic                  i_req_ready = 1'b0;
    logic [CPU_WIDTH-1:0]  o_req_addr;
    logic                  i_rsp_valid = 1'b0;
    logic [INST_WIDTH-1:0] i_rsp_data = '0;
    logic                  o_valid;
    logic                  i_ready = 1'b0;
    logic [INST_WIDTH-1:0] o_inst;
    logic [CPU_WIDTH-1:0]  o_pc;

    ifu_fetch #(
        .CPU_WIDTH  (CPU_WIDTH),
        .INST_WIDTH (INST_WIDTH),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_pc        (i_pc),
        .i_flush     (i_flush),
        .o_pcwen     (o_pcwen),
        .o_req_valid (o_req_valid),
        .i_req_ready (i_req_ready),
        .o_req_addr  (o_req_addr),
        .i_rsp_valid (i_rsp_valid),
        .i_rsp_data  (i_rsp_data),
        .o_valid     (o_valid),
        .i_ready     (i_ready),
        .o_inst      (o_inst),
        .o_pc        (o_pc)
    );

    always #5 i_clk = ~i_clk;

    int nVectors = 0;
    int nMiscompares = 0;

    // Reference model state: buffered entries, one outstanding fetch, PC unit.
    fetch_entry_t          expq[$];
    bit                    mOut = 0;
    bit                    mKept = 0;
    logic [CPU_WIDTH-1:0]  mPendPc = '0;
    logic [INST_WIDTH-1:0] mPendInst = '0;
    int                    mWait = 0;
    int                    curLat = 1;
    logic [CPU_WIDTH-1:0]  pcReg = 64'h8000_0000;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nVectors++;
        if (obs !== exp) begin
            nMiscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // One clock cycle: drive inputs, check outputs against the model, advance the model.
    task automatic applyStimulus(input bit flush, input bit reqRdy, input bit rdy,
                                 input logic [CPU_WIDTH-1:0] target, input bit stray);
        bit rsp, eReq, eFire, eValid;
        @(negedge i_clk);
        rsp         = mOut && (mWait == 0);
        i_pc        = pcReg;
        i_flush     = flush;
        i_req_ready = reqRdy;
        i_ready     = rdy;
        i_rsp_valid = rsp | stray;
        i_rsp_data  = rsp ? mPendInst : INST_WIDTH'($urandom);
        #1;
        eReq   = !mOut && (expq.size() < DEPTH) && !flush;
        eFire  = eReq && reqRdy;
        eValid = (expq.size() > 0) && !flush;
        checkOutput("req_valid", 64'(o_req_valid), 64'(eReq));
        checkOutput("pcwen", 64'(o_pcwen), 64'(eFire || flush));
        checkOutput("valid", 64'(o_valid), 64'(eValid));
        if (eReq) checkOutput("req_addr", o_req_addr, pcReg);
        if (eValid) begin
            checkOutput("o_pc", o_pc, expq[0].pc);
            checkOutput("o_inst", 64'(o_inst), 64'(expq[0].inst));
        end
        if (eValid && rdy) void'(expq.pop_front());
        if (rsp) begin
            if (mKept && !flush) expq.push_back('{pc: mPendPc, inst: mPendInst});
            mOut = 0;
        end else if (mOut && mWait > 0) begin
            mWait--;
        end
        if (flush) begin
            mKept = 0;
            expq.delete();
        end
        if (eFire) begin
            mOut      = 1;
            mKept     = 1;
            mPendPc   = pcReg;
            mPendInst = INST_WIDTH'($urandom);
            mWait     = curLat - 1;
        end
        if (flush) pcReg = target;
        else if (eFire) pcReg = pcReg + 64'd4;
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_req_valid"}, 64'(o_req_valid), 64'd0);
        checkOutput({tag, "_valid"}, 64'(o_valid), 64'd0);
        checkOutput({tag, "_pcwen"}, 64'(o_pcwen), 64'd0);
    endtask

    task automatic modelReset(input logic [CPU_WIDTH-1:0] startPc);
        expq.delete();
        mOut  = 0;
        mKept = 0;
        pcReg = startPc;
    endtask

    initial begin
        bit reached;
        logic [CPU_WIDTH-1:0] tgt;

        // Power-on reset.
        i_req_ready = 1'b1;
        #12;
        checkResetOutputs("por");
        @(posedge i_clk);
        #2 i_rst_n = 1'b1;
        modelReset(64'h8000_0000);

        // IF/ID stalled: the buffer fills with two entries, then requests stop.
        curLat = 1;
        for (int i = 0; i < 8; i++) applyStimulus(0, 1, 0, '0, 0);
        checkOutput("buffered_count", 64'(expq.size()), 64'd2);
        applyStimulus(0, 1, 1, '0, 0);
        for (int i = 0; i < 4; i++) applyStimulus(0, 1, 0, '0, 0);
        for (int i = 0; i < 12; i++) applyStimulus(0, 1, 1, '0, 0);

        // Flush while a 3-cycle response is outstanding.
        curLat = 3;
        reached = 0;
        for (int i = 0; i < 10 && !reached; i++) begin
            if (mOut && mKept && mWait > 0) reached = 1;
            else applyStimulus(0, 1, 1, '0, 0);
        end
        checkOutput("reach_wait_slow", 64'(reached), 64'd1);
        applyStimulus(1, 1, 1, 64'h8000_0100, 0);
        for (int i = 0; i < 10; i++) applyStimulus(0, 1, 1, '0, 0);

        // Flush coinciding with the response.
        curLat = 1;
        reached = 0;
        for (int i = 0; i < 10 && !reached; i++) begin
            if (mOut && mWait == 0) reached = 1;
            else applyStimulus(0, 1, 1, '0, 0);
        end
        checkOutput("reach_wait_fast", 64'(reached), 64'd1);
        applyStimulus(1, 1, 1, 64'h8000_0200, 0);
        for (int i = 0; i < 6; i++) applyStimulus(0, 1, 1, '0, 0);

        // Memory not ready for four cycles.
        for (int i = 0; i < 4; i++) applyStimulus(0, 0, 1, '0, 0);
        for (int i = 0; i < 4; i++) applyStimulus(0, 1, 1, '0, 0);

        // Randomized traffic.
        for (int i = 0; i < 1500; i++) begin
            curLat = int'($urandom_range(1, 4));
            tgt = 64'h8000_0000 + 64'($urandom_range(0, 255) << 2);
            applyStimulus($urandom_range(0, 99) < 8, $urandom_range(0, 99) < 70,
                          $urandom_range(0, 99) < 60, tgt, 0);
        end

        // Reset while a fetch is outstanding with one entry buffered.
        applyStimulus(1, 0, 1, 64'h8000_0400, 0);
        curLat = 6;
        reached = 0;
        for (int i = 0; i < 20 && !reached; i++) begin
            if (mOut && expq.size() == 1) reached = 1;
            else applyStimulus(0, 1, 0, '0, 0);
        end
        checkOutput("reach_wait_buffered", 64'(reached), 64'd1);
        @(negedge i_clk);
        i_flush     = 1'b0;
        i_rsp_valid = 1'b0;
        i_req_ready = 1'b1;
        i_rst_n     = 1'b0;
        #1;
        checkResetOutputs("midrst");
        modelReset(64'h8000_0800);
        i_pc = pcReg;
        @(posedge i_clk);
        #2 i_rst_n = 1'b1;
        curLat = 1;
        applyStimulus(0, 1, 1, '0, 1);
        for (int i = 0; i < 10; i++) applyStimulus(0, 1, 1, '0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
        $finish;
    end

endmodule

// File: doc/ifu_fetch.md
Name: ifu_fetch

Overview:
- Instruction-fetch front end; the consumer side of the branch/PC unit's next-PC interface.
- Takes the current PC and the taken-branch flush, and drives the PC write-enable back to that unit.
- Issues one-outstanding requests to instruction memory and buffers returned instructions with their PCs in a small FIFO.
- Presents instructions to the IF/ID boundary with a valid/ready handshake.

Parameters:
- CPU_WIDTH, 64, PC and address width.
- INST_WIDTH, 32, instruction width.
- FIFO_DEPTH, 2, buffered {pc, inst} entries; power of two, at least 2.

Ports:
- i_clk  input  1  clock
- i_rst_n  input  1  asynchronous active-low reset
- i_pc  input  CPU_WIDTH  current PC from the PC unit
- i_flush  input  1  taken jump/branch; the current PC and all buffered/in-flight fetches are wrong-path
- o_pcwen  output  1  PC update enable back to the PC unit
- o_req_valid  output  1  instruction memory request valid
- i_req_ready  input  1  memory accepts request
- o_req_addr  output  CPU_WIDTH  request address
- i_rsp_valid  input  1  response valid; no backpressure
- i_rsp_data  input  INST_WIDTH  response instruction
- o_valid  output  1  instruction available to IF/ID
- i_ready  input  1  IF/ID accepts
- o_inst  output  INST_WIDTH  instruction at FIFO head
- o_pc  output  CPU_WIDTH  PC of that instruction

Behaviour:
- Reset (async): state=IDLE, FIFO count=0, rd/wr pointers=0, req_pc=0.
- Reset outputs: o_req_valid=0, o_valid=0, o_pcwen=0.
- FSM state IDLE: no request outstanding.
- FSM state WAIT: one request outstanding; its response is kept.
- FSM state DRAIN: one request outstanding; its response is discarded.
- Space: space = (count < FIFO_DEPTH). Only IDLE issues, so an outstanding response always has a slot reserved.
- Request: o_req_valid = (state==IDLE) & space & ~i_flush. o_req_addr = i_pc.
- Valid withdrawal: valid may drop before acceptance only in a flush cycle. The address changes only after such a cycle.
- Fire: fire = o_req_valid & i_req_ready. On fire, req_pc <= i_pc and state -> WAIT.
- PC enable: o_pcwen = fire | i_flush.
  - Fire alone: PC unit advances to pc+4.
  - Flush: PC unit loads the jump target. Fire and flush are mutually exclusive by construction.
- WAIT, i_rsp_valid & ~i_flush: push {req_pc, i_rsp_data}; state -> IDLE.
- WAIT, i_flush & ~i_rsp_valid: state -> DRAIN.
- WAIT, i_flush & i_rsp_valid: discard; state -> IDLE.
- DRAIN, i_rsp_valid: discard; state -> IDLE. Flush in DRAIN changes nothing.
- IDLE, i_rsp_valid: protocol error; ignored.
- Memory latency: response at least 1 cycle after fire, unbounded. Throughput is 1 instruction per 2 cycles at 1-cycle memory latency.
- Output: o_valid = (count!=0) & ~i_flush; o_inst/o_pc = head entry. Pop on o_valid & i_ready.
- Flush and FIFO: flush empties the FIFO at the next edge (count=0, pointers reset), overriding any push or pop that cycle.
- Push and pop in the same cycle: count unchanged.
- Full FIFO: no request issued until a pop.
- Wrap-around: pointer arithmetic is modulo FIFO_DEPTH.
- Reset mid-operation: an in-flight memory response arriving after reset release while in IDLE is ignored. The memory side shares the same reset.

Decomposition:
- Shared package (core defines alongside CPU_WIDTH) holds:
  - the fetch state enum (IDLE, WAIT, DRAIN, 2-bit);
  - the fetch entry struct {pc, inst};
  - INST_WIDTH.
- One sub-module: fetch_fifo.
  - Parameterised depth/width FIFO with push, pop, synchronous clear, count, head.
  - Reused later for a deeper prefetch queue.
- FSM and PC handshake stay in ifu_fetch.

Test Plan:
- Reset release, i_pc=0x80000000, i_req_ready=1, 1-cycle memory:
  - first fire at the first edge after reset;
  - o_pcwen=1 in the fire cycle;
  - o_inst/o_pc = rsp / 0x80000000 one cycle later;
  - steady pattern is 1 push every 2 cycles.
- i_ready=0 held:
  - exactly 2 entries buffered (pc 0x80000000, 0x80000004);
  - o_req_valid stays 0 thereafter;
  - one pop re-enables exactly one request.
- Flush while in WAIT, response delayed 3 cycles:
  - o_pcwen=1 in the flush cycle;
  - FIFO cleared, state DRAIN;
  - late response discarded;
  - next fire uses the target PC (e.g. 0x80000100) and only that instruction appears.
- Flush coinciding with i_rsp_valid in WAIT: response dropped, state IDLE, count 0, next request at target.
- i_req_ready low for 4 cycles: o_req_valid and o_req_addr stable; o_pcwen=0 until the accepting cycle.
- Assert i_rst_n low while WAIT with 1 entry buffered:
  - outputs 0 immediately (async);
  - after release, stray i_rsp_valid ignored;
  - fetch restarts from i_pc.
